// File: rtl/player_motion_ctl.sv
// Per-player horizontal motion with a gated obstacle, updated once per v_tick rising edge.
// Optional vertical jump FSM per player is built only when PLAYER_JUMP_EN is defined.
module player_motion_ctl #(
  parameter int unsigned N_PLAYERS  = 2,
  parameter int unsigned XW         = 12,
  parameter int unsigned X_MAX      = 660,
  parameter int unsigned GATE_LO    = 310,
  parameter int unsigned GATE_HI    = 450,
  parameter int unsigned STEP       = 1,
  parameter int unsigned Y_GROUND   = 500,
  parameter int unsigned JUMP_TICKS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    v_tick,
  input  logic [N_PLAYERS-1:0]    m_left,
  input  logic [N_PLAYERS-1:0]    m_right,
  input  logic                    gate_open,
  input  logic [N_PLAYERS-1:0]    jump,
  output logic [N_PLAYERS*XW-1:0] xpos,
  output logic [N_PLAYERS*XW-1:0] ypos,
  output logic [N_PLAYERS*2-1:0]  state
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLeft    = 2'd1,
    StRight   = 2'd2,
    StBlocked = 2'd3
  } mv_state_e;

  // Candidates are formed one bit wider so x+STEP cannot wrap before clamping.
  localparam logic [XW:0]   XMaxW     = (XW+1)'(X_MAX);
  localparam logic [XW:0]   StepW     = (XW+1)'(STEP);
  localparam logic [XW:0]   GateLoW   = (XW+1)'(GATE_LO);
  localparam logic [XW:0]   GateHiW   = (XW+1)'(GATE_HI);
  localparam logic [XW:0]   GateLoM1W = (XW+1)'(GATE_LO - 1);
  localparam logic [XW:0]   GateHiP1W = (XW+1)'(GATE_HI + 1);
  localparam logic [XW-1:0] YGround   = XW'(Y_GROUND);

  logic tick_q, tick_d;
  logic upd;

  always_comb begin
    tick_d = v_tick;
    upd    = v_tick & ~tick_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= tick_d;
  end

`ifdef PLAYER_JUMP_EN
  typedef enum logic [1:0] {
    JGround = 2'd0,
    JUp     = 2'd1,
    JDown   = 2'd2
  } jump_e;

  localparam int unsigned    CntW       = $clog2(JUMP_TICKS + 1);
  localparam logic [CntW-1:0] JumpTicksC = CntW'(JUMP_TICKS);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [XW-1:0]   YOne       = XW'(1);
`else
  logic unused_jump;
  assign unused_jump = ^jump;
`endif

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_player
    logic [XW-1:0] x_q, x_d;
    mv_state_e     st_q, st_d;
    logic [XW:0]   x_ext, sum_r, cand_r, cand_l;

    always_comb begin
      x_ext  = {1'b0, x_q};
      sum_r  = x_ext + StepW;
      cand_r = (sum_r > XMaxW) ? XMaxW : sum_r;
      // Closed gate stops a player approaching from outside; one already inside moves freely.
      if (!gate_open && (x_ext < GateLoW) && (cand_r >= GateLoW)) cand_r = GateLoM1W;
      cand_l = (x_ext >= StepW) ? (x_ext - StepW) : '0;
      if (!gate_open && (x_ext > GateHiW) && (cand_l <= GateHiW)) cand_l = GateHiP1W;

      x_d  = x_q;
      st_d = st_q;
      if (upd) begin
        unique case ({m_left[g], m_right[g]})
          2'b01: begin
            x_d  = cand_r[XW-1:0];
            st_d = (cand_r == x_ext) ? StBlocked : StRight;
          end
          2'b10: begin
            x_d  = cand_l[XW-1:0];
            st_d = (cand_l == x_ext) ? StBlocked : StLeft;
          end
          default: st_d = StIdle;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x_q  <= '0;
        st_q <= StIdle;
      end else begin
        x_q  <= x_d;
        st_q <= st_d;
      end
    end

    assign xpos[g*XW +: XW] = x_q;
    assign state[g*2 +: 2]  = st_q;

`ifdef PLAYER_JUMP_EN
    jump_e           ph_q, ph_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XW-1:0]   y_q, y_d;

    always_comb begin
      ph_d  = ph_q;
      cnt_d = cnt_q;
      y_d   = y_q;
      if (upd) begin
        unique case (ph_q)
          JGround: begin
            // The launching update already counts as the first ascent step.
            if (jump[g]) begin
              ph_d  = JUp;
              cnt_d = CntOne;
              y_d   = y_q - YOne;
            end
          end
          JUp: begin
            if (cnt_q == JumpTicksC) begin
              ph_d  = ((y_q + YOne) == YGround) ? JGround : JDown;
              cnt_d = '0;
              y_d   = y_q + YOne;
            end else begin
              cnt_d = cnt_q + CntOne;
              y_d   = y_q - YOne;
            end
          end
          JDown: begin
            y_d = y_q + YOne;
            if ((y_q + YOne) == YGround) ph_d = JGround;
          end
          default: ph_d = JGround;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ph_q  <= JGround;
        cnt_q <= '0;
        y_q   <= YGround;
      end else begin
        ph_q  <= ph_d;
        cnt_q <= cnt_d;
        y_q   <= y_d;
      end
    end

    assign ypos[g*XW +: XW] = y_q;
`else
    assign ypos[g*XW +: XW] = YGround;
`endif
  end

endmodule
